// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-level SPI slave front end.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        HOLD   = 2'd2,
        RELOAD = 2'd3
    } spi_state_t;

    localparam int SPI_DATA_WIDTH_DEFAULT = 8;
    localparam int SYNC_STAGES            = 2;
    localparam int RELOAD_DELAY           = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// The rise/fall pulses are single-cycle and appear two clk edges after the
// pin changes, so the consumer acts on them at the third edge.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Synchroniser chain plus one history flop; reset to the idle pin level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
            r_hist <= RESET_LEVEL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= w_level;
        end
    end

    assign o_rise = w_level & ~r_hist;
    assign o_fall = ~w_level & r_hist;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode 0, MSB-first byte slave. Oversamples the pins in the clk domain,
// deserialises each byte onto data_in_byte with a READY_HOLD-cycle ready
// level, and serialises data_out_byte onto miso, reloading it two cycles
// after ready falls so the hoarder has time to advance its pointer.
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT,
    parameter int READY_HOLD     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic [SPI_DATA_WIDTH-1:0] data_in_byte,
    output logic                      ready,
    input  logic [SPI_DATA_WIDTH-1:0] data_out_byte
);

    localparam int BIT_CNT_W  = $clog2(SPI_DATA_WIDTH);
    localparam int WAIT_CNT_W = $clog2(READY_HOLD + RELOAD_DELAY);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT    = BIT_CNT_W'(SPI_DATA_WIDTH - 1);
    localparam logic [WAIT_CNT_W-1:0] HOLD_LAST   = WAIT_CNT_W'(READY_HOLD - 1);
    localparam logic [WAIT_CNT_W-1:0] RELOAD_LAST = WAIT_CNT_W'(RELOAD_DELAY - 1);

    spi_state_t                r_state;
    spi_state_t                w_next;
    logic [BIT_CNT_W-1:0]      r_bit_cnt;
    logic [WAIT_CNT_W-1:0]     r_wait_cnt;
    logic [SPI_DATA_WIDTH-2:0] r_rx;
    logic [SPI_DATA_WIDTH-1:0] r_tx;
    logic [SPI_DATA_WIDTH-1:0] r_data_in;
    logic [SYNC_STAGES-1:0]    r_mosi_sync;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_rx_sample;
    logic w_byte_done;
    logic w_tx_shift;
    logic w_tx_load;
    logic w_ready;

    spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sclk_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b1)) u_cs_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // MOSI delayed by the same synchroniser depth so it lines up with sclk samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a cs_n rise aborts from anywhere and wins over sclk
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_next = SHIFT;
            SHIFT:   if (w_sclk_rise && (r_bit_cnt == LAST_BIT)) w_next = HOLD;
            HOLD:    if (r_wait_cnt == HOLD_LAST) w_next = RELOAD;
            RELOAD:  if (r_wait_cnt == RELOAD_LAST) w_next = SHIFT;
            default: w_next = IDLE;
        endcase
        if (w_cs_rise) w_next = IDLE;
    end

    // Outputs and datapath strobes decoded from the current state
    always_comb begin
        w_ready     = 1'b0;
        w_tx_load   = 1'b0;
        w_rx_sample = 1'b0;
        w_tx_shift  = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_load = w_cs_fall;
            end
            SHIFT: begin
                w_rx_sample = w_sclk_rise & ~w_cs_rise;
                // The fall right after a byte boundary (count 0) must not shift:
                // the freshly reloaded MSB is already on miso.
                w_tx_shift  = w_sclk_fall & (r_bit_cnt != '0) & ~w_cs_rise;
            end
            HOLD: begin
                w_ready = 1'b1;
            end
            RELOAD: begin
                w_tx_load = (r_wait_cnt == RELOAD_LAST) & ~w_cs_rise;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign w_byte_done = w_rx_sample & (r_bit_cnt == LAST_BIT);

    // Shift registers, bit counter, completed byte and HOLD/RELOAD cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx       <= '0;
            r_tx       <= '0;
            r_data_in  <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_cs_rise) begin
                r_rx      <= '0;
                r_tx      <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_tx_load) begin
                    r_tx <= data_out_byte;
                end else if (w_tx_shift) begin
                    r_tx <= {r_tx[SPI_DATA_WIDTH-2:0], 1'b0};
                end
                if (w_byte_done) begin
                    r_data_in <= {r_rx, w_mosi};
                    r_bit_cnt <= '0;
                end else if (w_rx_sample) begin
                    r_rx      <= {r_rx[SPI_DATA_WIDTH-3:0], w_mosi};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if ((w_next == r_state) && ((r_state == HOLD) || (r_state == RELOAD))) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign miso         = r_tx[SPI_DATA_WIDTH-1];
    assign data_in_byte = r_data_in;
    assign ready        = w_ready;

endmodule
